// File: rtl/wb_stage_pkg.sv
// Shared constants for the writeback stage: default widths and opcode encodings.
package wb_stage_pkg;

  localparam int WB_DATA_W = 8;
  localparam int WB_ADDR_W = 3;
  localparam int WB_CNT_W  = 16;

  localparam logic [1:0] OP_ALU = 2'b00;
  localparam logic [1:0] OP_LI  = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;
  localparam logic [1:0] OP_NOP = 2'b11;

endpackage

// File: rtl/wb_stage_regfile.sv
// Register file with one write port and two combinational read ports that
// forward the in-flight write value when addresses collide.
module regfile_8x8
  import wb_stage_pkg::*;
#(
  parameter int DATA_W = WB_DATA_W,
  parameter int ADDR_W = WB_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr1_i,
  input  logic [ADDR_W-1:0] raddr2_i,
  output logic [DATA_W-1:0] rdata1_o,
  output logic [DATA_W-1:0] rdata2_o
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] regs_q [DEPTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
    end else if (we_i) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  // Write-through bypass so ID sees this cycle's writeback without a stall.
  always_comb begin
    rdata1_o = regs_q[raddr1_i];
    rdata2_o = regs_q[raddr2_i];
    if (we_i && (raddr1_i == waddr_i)) rdata1_o = wdata_i;
    if (we_i && (raddr2_i == waddr_i)) rdata2_o = wdata_i;
  end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: result select, register-file commit, branch redirect
// register and a saturating retired-instruction counter.
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int DATA_W = WB_DATA_W,
  parameter int ADDR_W = WB_ADDR_W,
  parameter int CNT_W  = WB_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] pc_EX_WB,
  input  logic [DATA_W-1:0] aluResult_EX_WB,
  input  logic [DATA_W-1:0] immOut_EX_WB,
  input  logic              branch_EX_WB,
  input  logic              regWrite_EX_WB,
  input  logic              immToReg_EX_WB,
  input  logic [ADDR_W-1:0] rd_EX_WB,
  input  logic [1:0]        opcode_EX_WB,
  input  logic [ADDR_W-1:0] rs1,
  input  logic [ADDR_W-1:0] rs2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2,
  output logic [DATA_W-1:0] wb_data,
  output logic              wb_we,
  output logic              redirect_valid,
  output logic [DATA_W-1:0] redirect_pc,
  output logic [CNT_W-1:0]  retired_count
);

  logic              redirect_valid_q, redirect_valid_d;
  logic [DATA_W-1:0] redirect_pc_q, redirect_pc_d;
  logic [CNT_W-1:0]  retired_q, retired_d;
  logic              retire;
  logic              unused_opcode;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Opcode is carried for debug visibility only; control bits decide everything.
  assign unused_opcode = ^opcode_EX_WB;

  assign wb_data = immToReg_EX_WB ? immOut_EX_WB : aluResult_EX_WB;
  assign wb_we   = regWrite_EX_WB;
  assign retire  = regWrite_EX_WB | branch_EX_WB;

  always_comb begin
    redirect_valid_d = branch_EX_WB;
    redirect_pc_d    = redirect_pc_q;
    retired_d        = retired_q;
    if (branch_EX_WB) redirect_pc_d = pc_EX_WB + immOut_EX_WB;
    if (retire)       retired_d     = sat_inc(retired_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      retired_q        <= '0;
    end else begin
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      retired_q        <= retired_d;
    end
  end

  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign retired_count  = retired_q;

  regfile_8x8 #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_regfile (
    .clk      (clk),
    .rst      (rst),
    .we_i     (regWrite_EX_WB),
    .waddr_i  (rd_EX_WB),
    .wdata_i  (wb_data),
    .raddr1_i (rs1),
    .raddr2_i (rs2),
    .rdata1_o (rdata1),
    .rdata2_o (rdata2)
  );

endmodule

// File: tb/tb_wb_stage.sv
// Scenario bench for wb_stage; a second instance with a 4-bit counter covers saturation.
module tb_wb_stage;
  import wb_stage_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] pc, alu, imm;
  logic       br, rw, i2r;
  logic [2:0] rd, rs1, rs2;
  logic [1:0] op;

  logic [7:0]  rdata1, rdata2, wb_data, redirect_pc;
  logic        wb_we, redirect_valid;
  logic [15:0] retired_count;

  logic [7:0] s_rdata1, s_rdata2, s_wb_data, s_redirect_pc;
  logic       s_wb_we, s_redirect_valid;
  logic [3:0] s_count;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_pc_q [$];
  logic [7:0] sb_exp;

  always #5 clk = ~clk;

  wb_stage dut (
    .clk(clk), .rst(rst), .pc_EX_WB(pc), .aluResult_EX_WB(alu), .immOut_EX_WB(imm),
    .branch_EX_WB(br), .regWrite_EX_WB(rw), .immToReg_EX_WB(i2r), .rd_EX_WB(rd),
    .opcode_EX_WB(op), .rs1(rs1), .rs2(rs2), .rdata1(rdata1), .rdata2(rdata2),
    .wb_data(wb_data), .wb_we(wb_we), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .retired_count(retired_count)
  );

  wb_stage #(.CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .pc_EX_WB(pc), .aluResult_EX_WB(alu), .immOut_EX_WB(imm),
    .branch_EX_WB(br), .regWrite_EX_WB(rw), .immToReg_EX_WB(i2r), .rd_EX_WB(rd),
    .opcode_EX_WB(op), .rs1(rs1), .rs2(rs2), .rdata1(s_rdata1), .rdata2(s_rdata2),
    .wb_data(s_wb_data), .wb_we(s_wb_we), .redirect_valid(s_redirect_valid),
    .redirect_pc(s_redirect_pc), .retired_count(s_count)
  );

  // Redirect scoreboard: every observed pulse must match the oldest queued target.
  always @(negedge clk) begin
    if (rst && redirect_valid) begin
      n_checks++;
      if (exp_pc_q.size() == 0) begin
        n_fail++;
        $display("FAIL redirect_spurious: got pc %h, no branch pending", redirect_pc);
      end else begin
        sb_exp = exp_pc_q.pop_front();
        if (redirect_pc !== sb_exp) begin
          n_fail++;
          $display("FAIL redirect_pc: got %h, expected %h", redirect_pc, sb_exp);
        end
      end
    end
  end

  task automatic drive(input logic b, input logic w, input logic im, input logic [7:0] p,
                       input logic [7:0] a, input logic [7:0] i, input logic [2:0] d,
                       input logic [1:0] o);
    logic [7:0] tgt;
    br = b; rw = w; i2r = im; pc = p; alu = a; imm = i; rd = d; op = o;
    if (b) begin
      tgt = p + i;
      exp_pc_q.push_back(tgt);
    end
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 3'd0, OP_NOP);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle(); op = OP_ALU; rs1 = 3'd0; rs2 = 3'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++; if (wb_data !== 8'h00) begin n_fail++; $display("FAIL rst_wb_data: got %h, expected 00", wb_data); end
    n_checks++; if (rdata1 !== 8'h00) begin n_fail++; $display("FAIL rst_rdata1: got %h, expected 00", rdata1); end
    n_checks++; if (rdata2 !== 8'h00) begin n_fail++; $display("FAIL rst_rdata2: got %h, expected 00", rdata2); end
    n_checks++; if (wb_we !== 1'b0) begin n_fail++; $display("FAIL rst_wb_we: got %b, expected 0", wb_we); end
    n_checks++; if (redirect_valid !== 1'b0) begin n_fail++; $display("FAIL rst_redirect_valid: got %b, expected 0", redirect_valid); end
    n_checks++; if (redirect_pc !== 8'h00) begin n_fail++; $display("FAIL rst_redirect_pc: got %h, expected 00", redirect_pc); end
    n_checks++; if (retired_count !== 16'd0) begin n_fail++; $display("FAIL rst_count: got %0d, expected 0", retired_count); end
    n_checks++; if (s_count !== 4'd0) begin n_fail++; $display("FAIL rst_sat_count: got %0d, expected 0", s_count); end
    #2 rst = 1'b1;
    next_cycle();
  endtask

  task automatic test_write_bypass();
    drive(1'b0, 1'b1, 1'b0, 8'h00, 8'h5A, 8'h00, 3'd3, OP_ALU); rs1 = 3'd3; rs2 = 3'd0;
    @(negedge clk);
    n_checks++; if (wb_data !== 8'h5A) begin n_fail++; $display("FAIL wr_wb_data: got %h, expected 5a", wb_data); end
    n_checks++; if (rdata1 !== 8'h5A) begin n_fail++; $display("FAIL wr_bypass_rdata1: got %h, expected 5a", rdata1); end
    n_checks++; if (rdata2 !== 8'h00) begin n_fail++; $display("FAIL wr_rdata2_r0: got %h, expected 00", rdata2); end
    n_checks++; if (wb_we !== 1'b1) begin n_fail++; $display("FAIL wr_wb_we: got %b, expected 1", wb_we); end
    next_cycle();
    idle(); rs1 = 3'd3;
    @(negedge clk);
    n_checks++; if (rdata1 !== 8'h5A) begin n_fail++; $display("FAIL wr_array_rdata1: got %h, expected 5a", rdata1); end
    n_checks++; if (retired_count !== 16'd1) begin n_fail++; $display("FAIL wr_count: got %0d, expected 1", retired_count); end
    next_cycle();
  endtask

  task automatic test_imm_select();
    drive(1'b0, 1'b1, 1'b1, 8'h00, 8'h11, 8'hF0, 3'd7, OP_LI); rs1 = 3'd7; rs2 = 3'd7;
    @(negedge clk);
    n_checks++; if (wb_data !== 8'hF0) begin n_fail++; $display("FAIL imm_wb_data: got %h, expected f0", wb_data); end
    n_checks++; if (rdata1 !== 8'hF0) begin n_fail++; $display("FAIL imm_bypass_rdata1: got %h, expected f0", rdata1); end
    n_checks++; if (rdata2 !== 8'hF0) begin n_fail++; $display("FAIL imm_bypass_rdata2: got %h, expected f0", rdata2); end
    next_cycle();
    idle(); rs1 = 3'd7; rs2 = 3'd3;
    @(negedge clk);
    n_checks++; if (rdata1 !== 8'hF0) begin n_fail++; $display("FAIL imm_array_r7: got %h, expected f0", rdata1); end
    n_checks++; if (rdata2 !== 8'h5A) begin n_fail++; $display("FAIL imm_array_r3: got %h, expected 5a", rdata2); end
    n_checks++; if (retired_count !== 16'd2) begin n_fail++; $display("FAIL imm_count: got %0d, expected 2", retired_count); end
    next_cycle();
  endtask

  task automatic test_branch_wrap();
    drive(1'b1, 1'b0, 1'b0, 8'hFE, 8'h00, 8'h05, 3'd0, OP_BR);
    @(negedge clk);
    n_checks++; if (redirect_valid !== 1'b0) begin n_fail++; $display("FAIL br_early_pulse: got %b, expected 0", redirect_valid); end
    next_cycle();
    idle();
    @(negedge clk);
    n_checks++; if (redirect_valid !== 1'b1) begin n_fail++; $display("FAIL br_pulse: got %b, expected 1", redirect_valid); end
    n_checks++; if (retired_count !== 16'd3) begin n_fail++; $display("FAIL br_count: got %0d, expected 3", retired_count); end
    next_cycle();
    @(negedge clk);
    n_checks++; if (redirect_valid !== 1'b0) begin n_fail++; $display("FAIL br_pulse_width: got %b, expected 0", redirect_valid); end
    n_checks++; if (redirect_pc !== 8'h03) begin n_fail++; $display("FAIL br_pc_hold: got %h, expected 03", redirect_pc); end
    next_cycle();
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 1'b0, 1'b0, 8'h08, 8'h00, 8'h08, 3'd0, OP_BR);
    next_cycle();
    drive(1'b1, 1'b0, 1'b0, 8'h10, 8'h00, 8'h10, 3'd0, OP_BR);
    @(negedge clk);
    n_checks++; if (redirect_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_pulse1: got %b, expected 1", redirect_valid); end
    next_cycle();
    drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 3'd0, OP_NOP);
    @(negedge clk);
    n_checks++; if (redirect_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_pulse2: got %b, expected 1", redirect_valid); end
    n_checks++; if (retired_count !== 16'd5) begin n_fail++; $display("FAIL b2b_count: got %0d, expected 5", retired_count); end
    next_cycle();
    drive(1'b1, 1'b1, 1'b0, 8'h30, 8'h44, 8'h02, 3'd5, OP_BR);
    @(negedge clk);
    n_checks++; if (redirect_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_bubble_pulse: got %b, expected 0", redirect_valid); end
    n_checks++; if (retired_count !== 16'd5) begin n_fail++; $display("FAIL b2b_bubble_count: got %0d, expected 5", retired_count); end
    next_cycle();
    idle(); rs1 = 3'd5;
    @(negedge clk);
    n_checks++; if (redirect_valid !== 1'b1) begin n_fail++; $display("FAIL link_pulse: got %b, expected 1", redirect_valid); end
    n_checks++; if (retired_count !== 16'd6) begin n_fail++; $display("FAIL link_count: got %0d, expected 6", retired_count); end
    n_checks++; if (rdata1 !== 8'h44) begin n_fail++; $display("FAIL link_r5: got %h, expected 44", rdata1); end
    next_cycle();
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 1'b0, 1'b0, 8'h20, 8'h00, 8'h01, 3'd0, OP_BR);
    next_cycle();
    drive(1'b0, 1'b1, 1'b0, 8'h00, 8'h77, 8'h00, 3'd2, OP_ALU); rs1 = 3'd2; rs2 = 3'd7;
    @(negedge clk);
    n_checks++; if (redirect_valid !== 1'b1) begin n_fail++; $display("FAIL mid_pre_pulse: got %b, expected 1", redirect_valid); end
    n_checks++; if (retired_count !== 16'd7) begin n_fail++; $display("FAIL mid_pre_count: got %0d, expected 7", retired_count); end
    #2 rst = 1'b0;
    #1;
    n_checks++; if (redirect_valid !== 1'b0) begin n_fail++; $display("FAIL mid_redirect_valid: got %b, expected 0", redirect_valid); end
    n_checks++; if (redirect_pc !== 8'h00) begin n_fail++; $display("FAIL mid_redirect_pc: got %h, expected 00", redirect_pc); end
    n_checks++; if (retired_count !== 16'd0) begin n_fail++; $display("FAIL mid_count: got %0d, expected 0", retired_count); end
    n_checks++; if (s_count !== 4'd0) begin n_fail++; $display("FAIL mid_sat_count: got %0d, expected 0", s_count); end
    @(posedge clk);
    #2 rst = 1'b1;
    drive(1'b0, 1'b1, 1'b0, 8'h00, 8'h3C, 8'h00, 3'd4, OP_ALU); rs1 = 3'd2; rs2 = 3'd7;
    @(negedge clk);
    n_checks++; if (rdata1 !== 8'h00) begin n_fail++; $display("FAIL mid_write_lost_r2: got %h, expected 00", rdata1); end
    n_checks++; if (rdata2 !== 8'h00) begin n_fail++; $display("FAIL mid_cleared_r7: got %h, expected 00", rdata2); end
    next_cycle();
    idle(); rs1 = 3'd4;
    @(negedge clk);
    n_checks++; if (rdata1 !== 8'h3C) begin n_fail++; $display("FAIL mid_first_write: got %h, expected 3c", rdata1); end
    n_checks++; if (retired_count !== 16'd1) begin n_fail++; $display("FAIL mid_post_count: got %0d, expected 1", retired_count); end
    next_cycle();
  endtask

  task automatic test_saturation();
    logic [3:0] exp_s;
    rst = 1'b0;
    #2 rst = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      drive(1'b0, 1'b1, 1'b0, 8'h00, 8'(i), 8'h00, 3'd1, OP_ALU);
      next_cycle();
      exp_s = (i > 15) ? 4'd15 : 4'(i);
      n_checks++; if (s_count !== exp_s) begin n_fail++; $display("FAIL sat_count[%0d]: got %0d, expected %0d", i, s_count, exp_s); end
      n_checks++; if (retired_count !== 16'(i)) begin n_fail++; $display("FAIL wide_count[%0d]: got %0d, expected %0d", i, retired_count, i); end
    end
    idle();
    next_cycle();
    n_checks++; if (s_count !== 4'd15) begin n_fail++; $display("FAIL sat_hold: got %0d, expected 15", s_count); end
  endtask

  initial begin
    test_reset();
    test_write_bypass();
    test_imm_select();
    test_branch_wrap();
    test_back_to_back();
    test_reset_mid();
    test_saturation();
    repeat (2) next_cycle();
    n_checks++;
    if (exp_pc_q.size() != 0) begin
      n_fail++;
      $display("FAIL redirect_missing: got %0d unmatched targets, expected 0", exp_pc_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
# wb_stage

Writeback stage of the 8-bit pipeline, consuming the EX/WB pipeline register outputs. It selects the writeback value (ALU result or immediate) and commits it to the 8-entry register file, whose two read ports serve the ID stage. It also resolves taken branches into a registered one-cycle PC redirect and keeps a saturating retired-instruction counter for debug.

## Interface
- DATA_W, 8: datapath and register width
- ADDR_W, 3: register address width (2**ADDR_W registers)
- CNT_W, 16: retired-instruction counter width

- clk  in  1  clock; all state updates on posedge
- rst  in  1  reset, asynchronous, active-low
- pc_EX_WB  in  DATA_W  PC of the instruction in WB
- aluResult_EX_WB  in  DATA_W  ALU result
- immOut_EX_WB  in  DATA_W  sign-extended immediate / branch offset
- branch_EX_WB  in  1  instruction is a taken branch
- regWrite_EX_WB  in  1  write rd this cycle
- immToReg_EX_WB  in  1  1: write immediate, 0: write ALU result
- rd_EX_WB  in  ADDR_W  destination register
- opcode_EX_WB  in  2  opcode (00 ALU, 01 load-immediate, 10 branch, 11 NOP)
- rs1, rs2  in  ADDR_W  ID-stage read addresses
- rdata1, rdata2  out  DATA_W  read data, bypassed
- wb_data  out  DATA_W  selected writeback value (forwarding source for EX)
- wb_we  out  1  equals regWrite_EX_WB (forwarding qualifier)
- redirect_valid  out  1  one-cycle PC redirect pulse
- redirect_pc  out  DATA_W  branch target
- retired_count  out  CNT_W  retired-instruction count

## Operation
- wb_data = immToReg_EX_WB ? immOut_EX_WB : aluResult_EX_WB; combinational.
- Register file: 2**ADDR_W × DATA_W. All entries writable, including r0. Write on posedge when regWrite_EX_WB=1: regs[rd_EX_WB] <= wb_data.
- Read ports: combinational. If regWrite_EX_WB=1 and rsN==rd_EX_WB, then rdataN=wb_data (write-through bypass); otherwise rdataN=regs[rsN]. Both ports bypass independently; rs1==rs2 is legal.
- Branch: on posedge with branch_EX_WB=1, redirect_valid<=1 and redirect_pc<=pc_EX_WB+immOut_EX_WB, modulo 2**DATA_W (wrap, no carry out). Otherwise redirect_valid<=0, and redirect_pc holds its last value.
- branch_EX_WB and regWrite_EX_WB together (link): both actions occur in the same cycle.
- A retired instruction is any cycle with regWrite_EX_WB|branch_EX_WB. A cycle with both set counts once. A bubble (all controls 0, the EX/WB reset state) does not count.
- retired_count increments by 1 per retired instruction and saturates at 2**CNT_W-1. It does not wrap.
- opcode_EX_WB is informational only. No behaviour depends on it beyond the bubble rule; opcode 11 with controls 0 is a bubble.

## Timing
- Reset values: all registers 0, redirect_valid=0, redirect_pc=0, retired_count=0. Outputs rdata1, rdata2 and wb_data follow the combinational rules. With an all-zero EX/WB input, all outputs read 0.
- Reset asserted mid-operation clears all state immediately and drops any write or redirect in flight. After deassertion, the first posedge performs normal operation.
- Write latency: the value is visible through bypass in the same cycle and from the array in the next cycle.
- Redirect latency: 1 cycle after the branch is in WB; the pulse is exactly 1 cycle wide. Back-to-back branches produce back-to-back pulses, each carrying its own target.
- Counter updates 1 cycle after the retiring instruction.

## Structure
- Shared package holds DATA_W, ADDR_W, CNT_W defaults and the opcode constants OP_ALU=2'b00, OP_LI=2'b01, OP_BR=2'b10, OP_NOP=2'b11.
- One sub-module: regfile_8x8, which contains the storage array, the write port and both bypassed read ports. Writeback mux, redirect register and counter live in wb_stage.

## Test plan
- Reset, then regWrite=1, immToReg=0, rd=3, aluResult=0x5A; next cycle rs1=3 → rdata1=0x5A. In the write cycle, rs1=3 → 0x5A via bypass.
- immToReg=1, immOut=0xF0, aluResult=0x11, rd=7, rs1=rs2=7 → wb_data=0xF0, rdata1=rdata2=0xF0 in the same cycle. After the write, r7=0xF0.
- branch=1, pc=0xFE, immOut=0x05 → next cycle redirect_valid=1, redirect_pc=0x03 (wrap). The cycle after that, redirect_valid=0 and redirect_pc stays 0x03.
- Two consecutive branches, targets 0x10 then 0x20 → two adjacent pulses carrying 0x10 then 0x20. retired_count rises by 2; a bubble cycle between them adds 0.
- Preload retired_count near max (CNT_W=4 instance), retire 20 instructions → count holds at 15.
- Write r2=0x77, assert rst mid-cycle while regWrite=1 → all registers read 0, redirect_valid=0, retired_count=0 immediately. The write is lost.
